// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and helpers for the LC-3 datapath slice.
//   - aluk_e     : ALU function encoding (ALUK input)
//   - pcmux_e    : PC source encoding (PCMUX input)
//   - addr2mux_e : address-adder offset encoding (ADDR2MUX input)
//   - NZP_RESET  : condition-code value after reset (Z set)
//   - sext16()   : sign-extend a field whose sign bit sits at msb_index
package lc3_pkg;

    localparam logic [2:0] NZP_RESET = 3'b010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_PASSA = 2'b10,
        ALU_NOT   = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        PC_BUS   = 2'b00,
        PC_ADDER = 2'b01,
        PC_INC   = 2'b10,
        PC_HOLD  = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_OFF11 = 2'b00,
        ADDR2_OFF9  = 2'b01,
        ADDR2_OFF6  = 2'b10,
        ADDR2_ZERO  = 2'b11
    } addr2mux_e;

    // Shift the field's sign bit up to bit 15, then arithmetic-shift back down
    // so the sign bit is replicated into every bit above msb_index.
    function automatic logic [15:0] sext16(input logic [15:0] value, input logic [3:0] msb_index);
        logic [3:0]         shamt;
        logic signed [15:0] shifted;
        shamt   = 4'd15 - msb_index;
        shifted = $signed(value << shamt);
        return 16'(shifted >>> shamt);
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// lc3_regfile: general-purpose register file.
//   Clk, Reset       : clock, synchronous active-high reset (all registers to 0)
//   we, wr_idx, wr_data : single synchronous write port
//   rd1_idx/rd1_data, rd2_idx/rd2_data : two asynchronous read ports
// Reads are not bypassed: a same-cycle write is visible only after the edge.
module lc3_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             we,
    input  logic [2:0]       wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd1_idx,
    output logic [WIDTH-1:0] rd1_data,
    input  logic [2:0]       rd2_idx,
    output logic [WIDTH-1:0] rd2_data
);

    logic [WIDTH-1:0] regs_r [NREGS];

    // Register storage: reset clears every entry, otherwise one write per cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            regs_r[wr_idx] <= wr_data;
        end
    end

    assign rd1_data = regs_r[rd1_idx];
    assign rd2_data = regs_r[rd2_idx];

endmodule

// File: rtl/lc3_datapath.sv
// lc3_datapath: LC-3 datapath slice driven by the external sequencer FSM.
//   Clk, Reset            : clock, synchronous active-high reset
//   LD_*                  : register load strobes (MAR, MDR, IR, BEN, CC, REG, PC, LED)
//   Gate*                 : bus driver enables, priority PC > MDR > ALU > MARMUX
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK : mux/function selects
//   Mem_OE (active low)   : MDR loads Mem_rdata when low, the bus when high
//   Mem_rdata             : SRAM read data
//   MAR, MDR              : SRAM address / write data
//   PC, IR, LED           : display outputs
//   Opcode, IR_5, IR_11, BEN : decode feedback to the FSM
//   Bus_err               : more than one gate asserted this cycle
module lc3_datapath
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_REG,
    input  logic             LD_PC,
    input  logic             LD_LED,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic [1:0]       PCMUX,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             Mem_OE,
    input  logic [WIDTH-1:0] Mem_rdata,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] IR,
    output logic [11:0]      LED,
    output logic [3:0]       Opcode,
    output logic             IR_5,
    output logic             IR_11,
    output logic             BEN,
    output logic             Bus_err
);

    logic [WIDTH-1:0] pc_r, mar_r, mdr_r, ir_r;
    logic [11:0]      led_r;
    logic [2:0]       nzp_r;
    logic             ben_r;

    logic [2:0]       sr1_idx_s, dr_idx_s;
    logic [WIDTH-1:0] sr1_data_s, sr2_data_s;
    logic [WIDTH-1:0] alu_b_s, alu_s;
    logic [WIDTH-1:0] addr1_s, addr2_s, adder_s;
    logic [WIDTH-1:0] bus_s, pc_next_s, mdr_next_s;
    logic [2:0]       gate_cnt_s;
    logic             bus_err_s;
    logic [2:0]       nzp_next_s;
    logic             ben_next_s;

    lc3_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .Clk      (Clk),
        .Reset    (Reset),
        .we       (LD_REG),
        .wr_idx   (dr_idx_s),
        .wr_data  (bus_s),
        .rd1_idx  (sr1_idx_s),
        .rd1_data (sr1_data_s),
        .rd2_idx  (ir_r[2:0]),
        .rd2_data (sr2_data_s)
    );

    // Register index selection from IR fields (DRMUX=1 targets R7 for JSR linkage)
    always_comb begin
        if (SR1MUX) begin
            sr1_idx_s = ir_r[11:9];
        end else begin
            sr1_idx_s = ir_r[8:6];
        end
        if (DRMUX) begin
            dr_idx_s = 3'd7;
        end else begin
            dr_idx_s = ir_r[11:9];
        end
    end

    // ALU: B operand is SR2 or the 5-bit immediate, carry out is dropped
    always_comb begin
        if (SR2MUX) begin
            alu_b_s = sext16({11'b0, ir_r[4:0]}, 4'd4);
        end else begin
            alu_b_s = sr2_data_s;
        end
        case (aluk_e'(ALUK))
            ALU_ADD:   alu_s = sr1_data_s + alu_b_s;
            ALU_AND:   alu_s = sr1_data_s & alu_b_s;
            ALU_PASSA: alu_s = sr1_data_s;
            ALU_NOT:   alu_s = ~sr1_data_s;
            default:   alu_s = sr1_data_s;
        endcase
    end

    // Address adder feeding MARMUX and the PC branch/jump path
    always_comb begin
        if (ADDR1MUX) begin
            addr1_s = pc_r;
        end else begin
            addr1_s = sr1_data_s;
        end
        case (addr2mux_e'(ADDR2MUX))
            ADDR2_OFF11: addr2_s = sext16({5'b0, ir_r[10:0]}, 4'd10);
            ADDR2_OFF9:  addr2_s = sext16({7'b0, ir_r[8:0]}, 4'd8);
            ADDR2_OFF6:  addr2_s = sext16({10'b0, ir_r[5:0]}, 4'd5);
            ADDR2_ZERO:  addr2_s = {WIDTH{1'b0}};
            default:     addr2_s = {WIDTH{1'b0}};
        endcase
        adder_s = addr1_s + addr2_s;
    end

    // Bus driver with fixed priority; contention is flagged rather than resolved silently
    always_comb begin
        if (GatePC) begin
            bus_s = pc_r;
        end else if (GateMDR) begin
            bus_s = mdr_r;
        end else if (GateALU) begin
            bus_s = alu_s;
        end else if (GateMARMUX) begin
            bus_s = adder_s;
        end else begin
            bus_s = {WIDTH{1'b0}};
        end
        gate_cnt_s = {2'b00, GatePC} + {2'b00, GateMDR} + {2'b00, GateALU} + {2'b00, GateMARMUX};
        bus_err_s  = (gate_cnt_s > 3'd1);
    end

    // Next-value selection for PC, MDR, condition codes and branch enable
    always_comb begin
        case (pcmux_e'(PCMUX))
            PC_BUS:   pc_next_s = bus_s;
            PC_ADDER: pc_next_s = adder_s;
            PC_INC:   pc_next_s = pc_r + 16'd1;
            PC_HOLD:  pc_next_s = pc_r;
            default:  pc_next_s = pc_r;
        endcase
        if (Mem_OE == 1'b0) begin
            mdr_next_s = Mem_rdata;
        end else begin
            mdr_next_s = bus_s;
        end
        if (bus_s[WIDTH-1]) begin
            nzp_next_s = 3'b100;
        end else if (bus_s == {WIDTH{1'b0}}) begin
            nzp_next_s = 3'b010;
        end else begin
            nzp_next_s = 3'b001;
        end
        // Uses the current IR and NZP, so a same-cycle LD_IR/LD_CC does not affect it
        ben_next_s = |(ir_r[11:9] & nzp_r);
    end

    // Architectural state; Reset overrides every load strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r  <= {WIDTH{1'b0}};
            mar_r <= {WIDTH{1'b0}};
            mdr_r <= {WIDTH{1'b0}};
            ir_r  <= {WIDTH{1'b0}};
            led_r <= 12'h000;
            nzp_r <= NZP_RESET;
            ben_r <= 1'b0;
        end else begin
            if (LD_PC)  pc_r  <= pc_next_s;
            if (LD_MAR) mar_r <= bus_s;
            if (LD_MDR) mdr_r <= mdr_next_s;
            if (LD_IR)  ir_r  <= bus_s;
            if (LD_LED) led_r <= ir_r[11:0];
            if (LD_CC)  nzp_r <= nzp_next_s;
            if (LD_BEN) ben_r <= ben_next_s;
        end
    end

    assign MAR     = mar_r;
    assign MDR     = mdr_r;
    assign PC      = pc_r;
    assign IR      = ir_r;
    assign LED     = led_r;
    assign BEN     = ben_r;
    assign Opcode  = ir_r[15:12];
    assign IR_5    = ir_r[5];
    assign IR_11   = ir_r[11];
    assign Bus_err = bus_err_s;

endmodule

// File: tb/tb_lc3_datapath.sv
// tb_lc3_datapath: directed LC-3 sequences followed by random control words.
// A driver applies one control word per cycle and pushes the expected
// mid-cycle view (state from previous edges, Bus_err for the current word)
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_lc3_datapath;

    typedef struct {
        bit       reset;
        bit       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        bit       gpc, gmdr, galu, gmarmux;
        bit [1:0] pcmux, addr2mux, aluk;
        bit       drmux, sr1mux, sr2mux, addr1mux, mem_oe;
        bit [15:0] rdata;
    } ctl_t;

    typedef struct {
        int pc, mar, mdr, ir, led, ben, berr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE;
    logic [15:0] Mem_rdata, MAR, MDR, PC, IR;
    logic [11:0] LED;
    logic [3:0]  Opcode;
    logic        IR_5, IR_11, BEN, Bus_err;

    lc3_datapath dut (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_rdata(Mem_rdata),
        .MAR(MAR), .MDR(MDR), .PC(PC), .IR(IR), .LED(LED),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Bus_err(Bus_err)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int   m_pc, m_mar, m_mdr, m_ir, m_led, m_nzp, m_ben;
    int   m_r [8];
    bit   model_valid = 1'b0;
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic int sx(input int v, input int bits);
        int m;
        m = v & ((1 << bits) - 1);
        if (m >= (1 << (bits - 1))) m = m - (1 << bits);
        return m;
    endfunction

    function automatic ctl_t nop();
        ctl_t c;
        c = '{default: 0};
        c.mem_oe = 1'b1;
        c.pcmux  = 2'b11;
        return c;
    endfunction

    task automatic drive(input ctl_t c);
        Reset = c.reset;
        LD_MAR = c.ld_mar; LD_MDR = c.ld_mdr; LD_IR = c.ld_ir; LD_BEN = c.ld_ben;
        LD_CC = c.ld_cc; LD_REG = c.ld_reg; LD_PC = c.ld_pc; LD_LED = c.ld_led;
        GatePC = c.gpc; GateMDR = c.gmdr; GateALU = c.galu; GateMARMUX = c.gmarmux;
        PCMUX = c.pcmux; ADDR2MUX = c.addr2mux; ALUK = c.aluk;
        DRMUX = c.drmux; SR1MUX = c.sr1mux; SR2MUX = c.sr2mux; ADDR1MUX = c.addr1mux;
        Mem_OE = c.mem_oe; Mem_rdata = c.rdata;
    endtask

    // Behavioural next-state: everything on the right-hand side is pre-edge state.
    task automatic model_update(input ctl_t c);
        int sr1, a, b, alu, off, adder, bus, s, nzp_new, dr;
        if (c.reset) begin
            m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_led = 0;
            m_nzp = 2; m_ben = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 0;
        end else begin
            sr1 = c.sr1mux ? ((m_ir >> 9) & 7) : ((m_ir >> 6) & 7);
            a   = m_r[sr1];
            b   = c.sr2mux ? (sx(m_ir, 5) & 32'hFFFF) : m_r[m_ir & 7];
            case (c.aluk)
                2'd0:    alu = (a + b) % 65536;
                2'd1:    alu = a & b;
                2'd2:    alu = a;
                default: alu = 65535 - a;
            endcase
            case (c.addr2mux)
                2'd0:    off = sx(m_ir, 11);
                2'd1:    off = sx(m_ir, 9);
                2'd2:    off = sx(m_ir, 6);
                default: off = 0;
            endcase
            adder = ((c.addr1mux ? m_pc : a) + off) & 32'hFFFF;
            if (c.gpc)          bus = m_pc;
            else if (c.gmdr)    bus = m_mdr;
            else if (c.galu)    bus = alu;
            else if (c.gmarmux) bus = adder;
            else                bus = 0;
            s       = (bus >= 32768) ? bus - 65536 : bus;
            nzp_new = (s < 0) ? 4 : ((s == 0) ? 2 : 1);
            dr      = c.drmux ? 7 : ((m_ir >> 9) & 7);
            if (c.ld_ben) m_ben = ((((m_ir >> 9) & 7) & m_nzp) != 0) ? 1 : 0;
            if (c.ld_led) m_led = m_ir & 32'hFFF;
            if (c.ld_pc) begin
                case (c.pcmux)
                    2'd0:    m_pc = bus;
                    2'd1:    m_pc = adder;
                    2'd2:    m_pc = (m_pc + 1) % 65536;
                    default: m_pc = m_pc;
                endcase
            end
            if (c.ld_mar) m_mar = bus;
            if (c.ld_ir)  m_ir  = bus;
            if (c.ld_mdr) m_mdr = c.mem_oe ? bus : int'(c.rdata);
            if (c.ld_reg) m_r[dr] = bus;
            if (c.ld_cc)  m_nzp = nzp_new;
        end
    endtask

    task automatic step(input ctl_t c);
        exp_t e;
        @(posedge Clk);
        #1;
        drive(c);
        if (model_valid) begin
            e.pc = m_pc; e.mar = m_mar; e.mdr = m_mdr; e.ir = m_ir;
            e.led = m_led; e.ben = m_ben;
            e.berr = ((int'(c.gpc) + int'(c.gmdr) + int'(c.galu) + int'(c.gmarmux)) > 1) ? 1 : 0;
            sb_q.push_back(e);
        end
        model_update(c);
        model_valid = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation every falling edge
    always @(negedge Clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc",      {16'h0, PC},     e.pc);
            chk("mar",     {16'h0, MAR},    e.mar);
            chk("mdr",     {16'h0, MDR},    e.mdr);
            chk("ir",      {16'h0, IR},     e.ir);
            chk("led",     {20'h0, LED},    e.led);
            chk("ben",     {31'h0, BEN},    e.ben);
            chk("opcode",  {28'h0, Opcode}, (e.ir >> 12) & 15);
            chk("ir5",     {31'h0, IR_5},   (e.ir >> 5) & 1);
            chk("ir11",    {31'h0, IR_11},  (e.ir >> 11) & 1);
            chk("bus_err", {31'h0, Bus_err}, e.berr);
        end
    end

    // Small building blocks for the directed sequences
    task automatic t_mdr(input bit [15:0] v);
        ctl_t c; c = nop(); c.ld_mdr = 1'b1; c.mem_oe = 1'b0; c.rdata = v; step(c);
    endtask
    task automatic t_pc_from_mdr();
        ctl_t c; c = nop(); c.gmdr = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00; step(c);
    endtask
    task automatic t_ir_from_mdr();
        ctl_t c; c = nop(); c.gmdr = 1'b1; c.ld_ir = 1'b1; step(c);
    endtask
    task automatic t_reg_from_mdr(input bit drmux);
        ctl_t c; c = nop(); c.gmdr = 1'b1; c.ld_reg = 1'b1; c.drmux = drmux; step(c);
    endtask
    task automatic t_show_sr1(input bit sr1mux);
        ctl_t c; c = nop(); c.galu = 1'b1; c.aluk = 2'b10; c.sr1mux = sr1mux; c.ld_mar = 1'b1; step(c);
    endtask
    task automatic t_ben();
        ctl_t c; c = nop(); c.ld_ben = 1'b1; step(c);
    endtask

    initial begin
        ctl_t c;
        c = nop(); c.reset = 1'b1;
        drive(c);
        // Reset, then idle
        step(c);
        c = nop();
        repeat (3) step(c);
        // Fetch at 0x3000
        t_mdr(16'h3000); t_pc_from_mdr();
        c = nop(); c.gpc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b10; step(c);
        c = nop(); c.ld_mar = 1'b1; step(c);              // no gate: bus reads 0
        t_mdr(16'h1261); t_ir_from_mdr();
        // ADD R1, R1, #1 with R1 = 5
        t_mdr(16'h0005); t_reg_from_mdr(1'b0);
        c = nop(); c.sr2mux = 1'b1; c.galu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; step(c);
        t_show_sr1(1'b0); t_ben();
        // R0 = 0x7FFF + 1 -> negative
        t_mdr(16'h1021); t_ir_from_mdr(); t_mdr(16'h7FFF); t_reg_from_mdr(1'b0);
        c = nop(); c.sr2mux = 1'b1; c.galu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; step(c);
        t_show_sr1(1'b0);
        t_mdr(16'h0800); t_ir_from_mdr(); t_ben();
        // PC wrap from 0xFFFF
        t_mdr(16'hFFFF); t_pc_from_mdr();
        c = nop(); c.ld_pc = 1'b1; c.pcmux = 2'b10; step(c);
        // AND R0, R0, #0 -> zero
        t_mdr(16'h5020); t_ir_from_mdr();
        c = nop(); c.sr2mux = 1'b1; c.aluk = 2'b01; c.galu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; step(c);
        t_mdr(16'h0400); t_ir_from_mdr(); t_ben(); t_show_sr1(1'b0);
        // Branch: NOT of R0 gives N, BRn -2 at 0x3005
        c = nop(); c.aluk = 2'b11; c.galu = 1'b1; c.ld_cc = 1'b1; step(c);
        t_mdr(16'h09FE); t_ir_from_mdr(); t_ben();
        t_mdr(16'h3005); t_pc_from_mdr();
        c = nop(); c.ld_pc = 1'b1; c.pcmux = 2'b01; c.addr1mux = 1'b1; c.addr2mux = 2'b01; step(c);
        t_mdr(16'h0000);
        c = nop(); c.gmdr = 1'b1; c.ld_cc = 1'b1; step(c);
        t_ben();
        // LD_IR and LD_CC together with LD_BEN use the old IR and NZP
        t_mdr(16'h0E00);
        c = nop(); c.gmdr = 1'b1; c.ld_ir = 1'b1; c.ld_cc = 1'b1; c.ld_ben = 1'b1; step(c);
        t_ben();
        // JSR: R7 <- PC, PC <- PC + off11
        t_mdr(16'h4805); t_ir_from_mdr(); t_mdr(16'h3010); t_pc_from_mdr();
        c = nop(); c.drmux = 1'b1; c.gpc = 1'b1; c.ld_reg = 1'b1; step(c);
        c = nop(); c.ld_pc = 1'b1; c.pcmux = 2'b01; c.addr1mux = 1'b1; c.addr2mux = 2'b00; step(c);
        c = nop(); c.ld_led = 1'b1; step(c);
        t_mdr(16'h01C0); t_ir_from_mdr(); t_show_sr1(1'b0);
        // Gate conflict and PC self-load
        c = nop(); c.gpc = 1'b1; c.galu = 1'b1; c.ld_mar = 1'b1; step(c);
        c = nop(); c.gpc = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00; step(c);
        // Reset with every load asserted
        c = nop(); c.reset = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b10;
        c.ld_ir = 1'b1; c.ld_led = 1'b1; c.gpc = 1'b1; c.ld_reg = 1'b1; step(c);
        c = nop(); step(c);
        // Random control words
        for (int n = 0; n < 800; n++) begin
            c.reset    = ($urandom_range(0, 63) == 0);
            c.ld_mar   = $urandom_range(0, 1); c.ld_mdr = $urandom_range(0, 1);
            c.ld_ir    = $urandom_range(0, 1); c.ld_ben = $urandom_range(0, 1);
            c.ld_cc    = $urandom_range(0, 1); c.ld_reg = $urandom_range(0, 1);
            c.ld_pc    = $urandom_range(0, 1); c.ld_led = $urandom_range(0, 1);
            c.gpc      = ($urandom_range(0, 3) == 0); c.gmdr = ($urandom_range(0, 3) == 0);
            c.galu     = ($urandom_range(0, 3) == 0); c.gmarmux = ($urandom_range(0, 3) == 0);
            c.pcmux    = 2'($urandom_range(0, 3)); c.addr2mux = 2'($urandom_range(0, 3));
            c.aluk     = 2'($urandom_range(0, 3));
            c.drmux    = $urandom_range(0, 1); c.sr1mux = $urandom_range(0, 1);
            c.sr2mux   = $urandom_range(0, 1); c.addr1mux = $urandom_range(0, 1);
            c.mem_oe   = $urandom_range(0, 1);
            c.rdata    = 16'($urandom);
            step(c);
        end
        c = nop(); step(c);
        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge Clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_datapath.md
Name: lc3_datapath

Overview:
- 16-bit LC-3 datapath slice that sits directly downstream of the instruction-sequencer/decode FSM.
- Consumes every load, gate and mux-select strobe that the FSM emits each cycle.
- Holds PC, MAR, MDR, IR, the register file, NZP, BEN and the LED latch, and drives a single internal bus.
- Feeds Opcode/IR_5/IR_11/BEN back to the FSM and MAR/MDR to the SRAM interface.

Parameters:
- WIDTH, 16, datapath word width; only 16 is supported.
- NREGS, 8, general-purpose register count; index width is 3.

Ports:
- Clk  in  1  clock
- Reset  in  1  sync active-high reset
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load strobes
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers
- PCMUX  in  2  PC source select
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in  1 each  mux selects
- ADDR2MUX  in  2  offset select
- ALUK  in  2  ALU function
- Mem_OE  in  1  active-low; selects the MDR source
- Mem_rdata  in  16  SRAM read data
- MAR  out  16  memory address
- MDR  out  16  memory write data
- PC, IR  out  16 each  for hex display
- LED  out  12  PAUSE display
- Opcode  out  4  IR[15:12]
- IR_5, IR_11  out  1 each  IR[5], IR[11]
- BEN  out  1  branch enable
- Bus_err  out  1  more than one gate asserted

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high; clock is Clk.
  - On Reset: PC, MAR, MDR, IR, all registers, LED = 0; NZP = 3'b010; BEN = 0.
  - All state updates on posedge Clk. Every load samples pre-edge combinational values.
- Bus (combinational):
  - Exactly one of PC / MDR / ALU / MARMUX drives the bus.
  - Priority if several gates are asserted: GatePC > GateMDR > GateALU > GateMARMUX. Bus_err = 1 in that same cycle.
  - No gate asserted: bus = 16'h0000, Bus_err = 0.
- Register-file sources:
  - SR1 index: SR1MUX 0 -> IR[8:6]; 1 -> IR[11:9].
  - SR2 index is always IR[2:0].
  - DR index: DRMUX 0 -> IR[11:9]; 1 -> 3'd7.
  - Reads are asynchronous. A write and a read of the same register in one cycle returns the old value (no bypass).
- ALU:
  - B operand: SR2MUX 0 -> SR2 out; 1 -> sext(IR[4:0]).
  - ALUK: 00 A+B (mod 2^16, carry discarded); 01 A&B; 10 A; 11 ~A.
- Address adder (MARMUX value):
  - ADDR1: 0 -> SR1 out; 1 -> PC.
  - ADDR2: 00 sext(IR[10:0]); 01 sext(IR[8:0]); 10 sext(IR[5:0]); 11 0.
  - Sum = ADDR1 + ADDR2, wraps mod 2^16.
- Register loads:
  - PC: PCMUX 00 bus; 01 adder sum; 10 PC+1 (FFFF wraps to 0000); 11 PC (hold).
  - LD_MAR: MAR <= bus. LD_IR: IR <= bus.
  - LD_MDR: MDR <= Mem_rdata if Mem_OE = 0, else bus.
  - LD_REG: R[DR] <= bus.
  - LD_CC: NZP <= {bus[15], bus == 0, ~bus[15] & bus != 0}. Exactly one bit is set.
  - LD_BEN: BEN <= |(IR[11:9] & NZP), using pre-edge IR and NZP.
  - LD_LED: LED <= IR[11:0].
- Simultaneous events:
  - LD_IR with LD_BEN in the same cycle: BEN uses the old IR.
  - LD_CC with LD_BEN in the same cycle: BEN uses the old NZP.
  - LD_PC with GatePC and PCMUX = 00: PC holds.
- Reset mid-operation dominates all loads.
- No internal FSM. Multi-cycle sequencing belongs to the upstream controller; this block is a registered datapath only.

Decomposition:
- Package lc3_pkg:
  - enums for ALUK (ALU_ADD, ALU_AND, ALU_PASSA, ALU_NOT), PCMUX, ADDR2MUX;
  - constant NZP_RESET = 3'b010;
  - function sext16(value, msb_index).
- Sub-module lc3_regfile: 8x16 registers, one sync write port, two async read ports, synchronous Reset to zero.
- ALU, bus mux and address adder stay inline.

Test Plan:
- Reset, then idle 3 cycles -> PC = 0, IR = 0, NZP = 010, BEN = 0, bus = 0, Bus_err = 0.
- Fetch: GatePC + LD_MAR + LD_PC, PCMUX = 10, at PC = 0x3000 -> MAR = 0x3000, PC = 0x3001. Next, Mem_OE = 0, LD_MDR, Mem_rdata = 0x1261 -> MDR = 0x1261. Next, GateMDR + LD_IR -> IR = 0x1261, Opcode = 0001, IR_5 = 1.
- ADD immediate: R1 = 0x0005, IR = 0x1261 (R1 <- R1 + 1). SR2MUX = 1, ALUK = 00, GateALU, LD_REG, LD_CC -> R1 = 0x0006, NZP = 001.
- Negative / wrap / zero: R0 = 0x7FFF, ADD 1 -> 0x8000, NZP = 100. PC = 0xFFFF with PCMUX = 10 -> PC = 0x0000. AND with 0 -> NZP = 010.
- Branch: NZP = 100, IR = 0x09FE (BRn -2), LD_BEN -> BEN = 1. Then PCMUX = 01, ADDR1 = PC, ADDR2 = 01, at PC = 0x3005 -> PC = 0x3003. Same IR with NZP = 010 -> BEN = 0.
- JSR + conflict: IR = 0x4805, PC = 0x3010. DRMUX = 1, GatePC, LD_REG -> R7 = 0x3010. Then PCMUX = 01, ADDR2 = 00 -> PC = 0x3015. GatePC and GateALU together -> bus = PC, Bus_err = 1.
